// File: rtl/psimd_sat_pipe.sv
// -----------------------------------------------------------------------------
// psimd_sat_pipe
// Pipelined packed-SIMD adder for the EX stage. Each word holds LANES
// independent LANE_W-bit lanes. Four lane operations are available: signed
// saturating add, signed saturating subtract, unsigned saturating add and
// wrapping add. Carries and borrows never cross lane boundaries. The pipeline
// has STAGES register stages, a valid/ready handshake with full backpressure,
// per-lane saturation flags, and a sticky counter of saturating words.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset (discards words in flight)
//   in_valid   : input word valid
//   in_ready   : unit can accept an input word this cycle
//   op         : 00 sadd-sat, 01 ssub-sat, 10 uadd-sat, 11 add-wrap
//   a, b       : packed operands, lane i = x[i*LANE_W +: LANE_W]
//   out_valid  : result valid
//   out_ready  : downstream accepts the result
//   result     : packed result
//   sat_lanes  : bit i set when lane i saturated (aligned with result)
//   sat_count  : number of delivered words with any lane saturated (sticky max)
//   sat_clr    : synchronous clear of sat_count (wins over an increment)
// -----------------------------------------------------------------------------
module psimd_sat_pipe #(
   parameter int LANE_W = 4,
   parameter int LANES  = 4,
   parameter int STAGES = 2,
   parameter int CNT_W  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [1:0]                op,
   input  logic [LANE_W*LANES-1:0]   a,
   input  logic [LANE_W*LANES-1:0]   b,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANE_W*LANES-1:0]   result,
   output logic [LANES-1:0]          sat_lanes,
   output logic [CNT_W-1:0]          sat_count,
   input  logic                      sat_clr
);

   localparam int W = LANE_W * LANES;

   // Clamp a LANE_W+1-bit signed value into LANE_W bits; returns {flag, lane}.
   // The two top bits differ exactly when the value is outside the lane range.
   function automatic logic [LANE_W:0] sat_signed(input logic signed [LANE_W:0] s);
      if (s[LANE_W] != s[LANE_W-1]) begin
         if (s[LANE_W])
            return {1'b1, 1'b1, {(LANE_W-1){1'b0}}};
         else
            return {1'b1, 1'b0, {(LANE_W-1){1'b1}}};
      end
      return {1'b0, s[LANE_W-1:0]};
   endfunction

   // Clamp an unsigned sum with carry-out to all-ones; returns {flag, lane}.
   function automatic logic [LANE_W:0] sat_unsigned(input logic [LANE_W:0] u);
      if (u[LANE_W])
         return {1'b1, {LANE_W{1'b1}}};
      return {1'b0, u[LANE_W-1:0]};
   endfunction

   function automatic logic [LANE_W:0] lane_op(input logic [LANE_W-1:0] x,
                                               input logic [LANE_W-1:0] y,
                                               input logic [1:0]        o);
      logic signed [LANE_W:0] sx;
      logic signed [LANE_W:0] sy;
      logic        [LANE_W:0] u;
      sx = {x[LANE_W-1], x};
      sy = {y[LANE_W-1], y};
      u  = {1'b0, x} + {1'b0, y};
      case (o)
         2'b00:   return sat_signed(sx + sy);
         2'b01:   return sat_signed(sx - sy);
         2'b10:   return sat_unsigned(u);
         default: return {1'b0, u[LANE_W-1:0]};
      endcase
   endfunction

   logic [W-1:0]      w_res;
   logic [LANES-1:0]  w_sat;
   logic [STAGES-1:0] w_rdy;

   logic [STAGES-1:0] r_vld_p;
   logic [W-1:0]      r_res_p [STAGES];
   logic [LANES-1:0]  r_sat_p [STAGES];
   logic [CNT_W-1:0]  r_cnt;

   genvar g;
   generate
      for (g = 0; g < LANES; g++) begin : g_lane
         logic [LANE_W:0] w_l;
         assign w_l = lane_op(a[g*LANE_W +: LANE_W], b[g*LANE_W +: LANE_W], op);
         assign w_res[g*LANE_W +: LANE_W] = w_l[LANE_W-1:0];
         assign w_sat[g]                  = w_l[LANE_W];
      end

      // Unrolled form of rdy[k] = rdy[k+1] | ~v[k]: stage k can move when the
      // output is accepted or any stage at or after k holds a bubble.
      for (g = 0; g < STAGES; g++) begin : g_rdy
         assign w_rdy[g] = out_ready | ~(&r_vld_p[STAGES-1:g]);
      end
   endgenerate

   assign in_ready = w_rdy[0];

   // ---- stage p0: capture the lane arithmetic ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld_p[0] <= 1'b0;
         r_res_p[0] <= '0;
         r_sat_p[0] <= '0;
      end else if (w_rdy[0]) begin
         r_vld_p[0] <= in_valid;
         r_res_p[0] <= w_res;
         r_sat_p[0] <= w_sat;
      end
   end

   // ---- stages p1..pN: carry data unchanged, hold when not ready ----
   generate
      for (g = 1; g < STAGES; g++) begin : g_stage
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_vld_p[g] <= 1'b0;
               r_res_p[g] <= '0;
               r_sat_p[g] <= '0;
            end else if (w_rdy[g]) begin
               r_vld_p[g] <= r_vld_p[g-1];
               r_res_p[g] <= r_res_p[g-1];
               r_sat_p[g] <= r_sat_p[g-1];
            end
         end
      end
   endgenerate

   assign out_valid = r_vld_p[STAGES-1];
   assign result    = r_res_p[STAGES-1];
   assign sat_lanes = r_sat_p[STAGES-1];

   // ---- saturation event counter: sticky at all-ones, clear has priority ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (sat_clr)
         r_cnt <= '0;
      else if (out_valid && out_ready && (|sat_lanes) && !(&r_cnt))
         r_cnt <= r_cnt + 1'b1;
   end

   assign sat_count = r_cnt;

endmodule

// File: tb/tb_psimd_sat_pipe.sv
// -----------------------------------------------------------------------------
// tb_psimd_sat_pipe
// Scoreboard bench for psimd_sat_pipe (LANE_W=4, LANES=4, STAGES=2, CNT_W=2).
// The driver pushes hand-computed expected words when a word is accepted; a
// negedge monitor pops and compares on every output transfer, and tracks the
// expected saturation counter.
// -----------------------------------------------------------------------------
module tb_psimd_sat_pipe;

   localparam int LW = 4;
   localparam int LN = 4;
   localparam int ST = 2;
   localparam int CW = 2;
   localparam int W  = LW * LN;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    op = 2'b00;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  result;
   logic [LN-1:0] sat_lanes;
   logic [CW-1:0] sat_count;
   logic          sat_clr = 1'b0;

   psimd_sat_pipe #(.LANE_W(LW), .LANES(LN), .STAGES(ST), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .sat_lanes (sat_lanes),
      .sat_count (sat_count),
      .sat_clr   (sat_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]  res;
      logic [LN-1:0] sat;
      int            acc;
      bit            lat;
   } exp_t;

   exp_t          sb[$];
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   int            accepted = 0;
   int            delivered = 0;
   bit            chk_lat = 1'b1;
   logic [CW-1:0] exp_cnt = '0;
   bit            prev_stall = 1'b0;
   logic [W-1:0]  prev_res = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   // Monitor: compare each delivered word and track the expected counter.
   always @(negedge clk) begin
      exp_t e;
      bit   sat_now;
      sat_now = 1'b0;
      if (rst) begin
         exp_cnt    = '0;
         prev_stall = 1'b0;
      end else begin
         chk("sat_count", 32'(sat_count), 32'(exp_cnt));
         if (prev_stall) begin
            chk("hold_valid", 32'(out_valid), 32'h1);
            chk("hold_result", 32'(result), 32'(prev_res));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_output: got %0h expected none", result);
            end else begin
               e = sb.pop_front();
               chk("result", 32'(result), 32'(e.res));
               chk("sat_lanes", 32'(sat_lanes), 32'(e.sat));
               if (e.lat) chk("latency", 32'(cyc - e.acc), 32'(ST));
               sat_now = |e.sat;
               delivered++;
            end
         end
         if (sat_clr)
            exp_cnt = '0;
         else if (out_valid && out_ready && sat_now && exp_cnt != '1)
            exp_cnt = exp_cnt + 1'b1;
         prev_stall = out_valid && !out_ready;
         prev_res   = result;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the word is accepted.
   task automatic send(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] er, input logic [LN-1:0] es);
      int   n;
      exp_t e;
      n = 0;
      op = o; a = x; b = y; in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 50) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no in_ready expected acceptance of %0h", er);
            in_valid = 1'b0;
            return;
         end
      end
      e.res = er; e.sat = es; e.acc = cyc; e.lat = chk_lat;
      sb.push_back(e);
      accepted++;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_result", 32'(result), 32'h0);
      chk("rst_sat_lanes", 32'(sat_lanes), 32'h0);
      chk("rst_sat_count", 32'(sat_count), 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", 32'(in_ready), 32'h1);
      @(posedge clk);
      #1;

      // Basic modes
      send(2'b00, 16'h783F, 16'h1F21, 16'h7850, 4'b1100);
      idle(4);
      chk("cnt_after_sadd", 32'(sat_count), 32'h1);
      send(2'b10, 16'h783F, 16'h1F21, 16'h8F5F, 4'b0101);
      send(2'b01, 16'h8000, 16'h1000, 16'h8000, 4'b1000);
      send(2'b11, 16'hFFFF, 16'h0001, 16'hFFF0, 4'b0000);
      idle(4);
      chk("cnt_after_modes", 32'(sat_count), 32'h3);

      // Clear, then five saturating words stick at 3
      sat_clr = 1'b1;
      idle(1);
      sat_clr = 1'b0;
      chk("cnt_cleared", 32'(sat_count), 32'h0);
      for (int i = 0; i < 5; i++) send(2'b00, 16'h783F, 16'h1F21, 16'h7850, 4'b1100);
      idle(4);
      chk("cnt_sticky", 32'(sat_count), 32'h3);

      // Clear colliding with a saturating transfer
      sat_clr = 1'b1;
      idle(1);
      sat_clr = 1'b0;
      send(2'b10, 16'h783F, 16'h1F21, 16'h8F5F, 4'b0101);
      idle(4);
      chk("cnt_one", 32'(sat_count), 32'h1);
      send(2'b01, 16'h8000, 16'h1000, 16'h8000, 4'b1000);
      @(posedge clk);
      #1 sat_clr = 1'b1;
      chk("collide_out_valid", 32'(out_valid), 32'h1);
      @(posedge clk);
      #1 sat_clr = 1'b0;
      chk("cnt_clear_wins", 32'(sat_count), 32'h0);
      idle(2);

      // Backpressure: 4 words offered, only 2 fit while out_ready is low
      out_ready = 1'b0;
      chk_lat   = 1'b0;
      base      = accepted;
      fork
         begin
            send(2'b10, 16'hF001, 16'h1001, 16'hF002, 4'b1000);
            send(2'b11, 16'h1234, 16'h1111, 16'h2345, 4'b0000);
            send(2'b00, 16'h0070, 16'h0010, 16'h0070, 4'b0010);
            send(2'b01, 16'h0001, 16'h0002, 16'h000F, 4'b0000);
         end
         begin
            repeat (6) @(posedge clk);
            #2;
            chk("bp_accepted", 32'(accepted - base), 32'h2);
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            out_ready = 1'b1;
         end
      join
      chk_lat = 1'b1;
      idle(6);
      chk("bp_drained", 32'(sb.size()), 32'h0);
      chk("cnt_after_bp", 32'(sat_count), 32'h2);

      // Asynchronous reset with two words in flight
      send(2'b00, 16'h783F, 16'h1F21, 16'h7850, 4'b1100);
      send(2'b10, 16'h783F, 16'h1F21, 16'h8F5F, 4'b0101);
      #2 rst = 1'b1;
      sb.delete();
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'h0);
      chk("midrst_sat_count", 32'(sat_count), 32'h0);
      chk("midrst_result", 32'(result), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      idle(1);
      send(2'b11, 16'h1234, 16'h1111, 16'h2345, 4'b0000);
      idle(5);
      chk("final_drained", 32'(sb.size()), 32'h0);
      chk("delivered_words", 32'(delivered), 32'd16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      bad++;
      $display("FAIL global_timeout: got no finish expected finish before 100000");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
